enc_sequencer: RTL

- Beat sequencer for the next-generation RS encoder datapath. Each beat carries ENC_SYM output symbols.
- Runtime-selectable shortened codes: message length K is set per codeword, parity length P is fixed.
- Codewords are packed back-to-back with no idle lanes.
- Every cycle it tells the message buffer, parity buffer and parity processor how the current beat splits between message and parity lanes, and where codeword boundaries fall.

---
 rtl/enc_pkg.sv | 22 ++
 rtl/enc_beat_classifier.sv | 68 ++++++
 rtl/enc_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - beat phase type, default sizes and message-length legality check for the RS encoder sequencer
package enc_pkg;

    typedef enum logic [1:0] {
        SEL_MES = 2'd0,
        SEL_MTP = 2'd1,
        SEL_PAR = 2'd2,
        SEL_PTM = 2'd3
    } sel_phase_t;

    localparam int ENC_SYM_DEF     = 8;
    localparam int RSC_PAR_LEN_DEF = 32;
    localparam int RSC_COD_MAX_DEF = 255;
    localparam int RSC_MES_MIN_DEF = 16;
    localparam int CW_COUNT_W      = 16;

    function automatic logic enc_mes_len_legal(input int mes_len, input int mes_min,
                                               input int cod_max, input int par_len);
        return (mes_len >= mes_min) && (mes_len <= cod_max - par_len);
    endfunction

endpackage

// File: rtl/enc_beat_classifier.sv
// rtl/enc_beat_classifier.sv - splits one beat into message/parity lanes and locates codeword boundaries
module enc_beat_classifier
    import enc_pkg::*;
#(
    parameter int ENC_SYM = ENC_SYM_DEF,
    parameter int SW      = 9
) (
    input  logic [SW-1:0]                cnt,
    input  logic [SW-1:0]                mes_len,
    input  logic [SW-1:0]                cod_len,
    output sel_phase_t                   phase,
    output logic [$clog2(ENC_SYM+1)-1:0] mes_request,
    output logic [$clog2(ENC_SYM+1)-1:0] par_request,
    output logic                         sop,
    output logic [$clog2(ENC_SYM)-1:0]   sop_lane,
    output logic                         eop,
    output logic [$clog2(ENC_SYM)-1:0]   eop_lane
);
    localparam int RW = $clog2(ENC_SYM + 1);
    localparam int LW = $clog2(ENC_SYM);
    localparam logic [SW-1:0] BEAT = SW'(ENC_SYM);

    logic [SW-1:0] beat_end;
    logic [SW-1:0] mes_cur;
    logic [SW-1:0] mes_nxt;
    logic [SW-1:0] mes_sum;
    logic [SW-1:0] par_sum;
    logic [SW-1:0] sop_off;
    logic [SW-1:0] eop_off;

    always_comb begin
        beat_end = cnt + BEAT;
        mes_cur  = '0;
        mes_nxt  = '0;
        phase    = SEL_MES;

        // Both message terms are clamped at zero before they are combined.
        if (mes_len > cnt) begin
            mes_cur = (mes_len - cnt > BEAT) ? BEAT : (mes_len - cnt);
        end
        if (beat_end > cod_len) begin
            mes_nxt = beat_end - cod_len;
        end
        mes_sum = mes_cur + mes_nxt;
        par_sum = BEAT - mes_sum;

        if (beat_end <= mes_len) begin
            phase = SEL_MES;
        end else if (cnt < mes_len) begin
            phase = SEL_MTP;
        end else if (beat_end <= cod_len) begin
            phase = SEL_PAR;
        end else begin
            phase = SEL_PTM;
        end

        sop     = (cnt == '0) || (phase == SEL_PTM);
        sop_off = (cnt == '0) ? '0 : (cod_len - cnt);
        eop     = (beat_end >= cod_len);
        eop_off = cod_len - cnt - SW'(1);
    end

    assign mes_request = RW'(mes_sum);
    assign par_request = RW'(par_sum);
    assign sop_lane    = LW'(sop_off);
    assign eop_lane    = LW'(eop_off);

endmodule

// File: rtl/enc_sequencer.sv
// rtl/enc_sequencer.sv - per-beat message/parity sequencer for back-to-back shortened RS codewords
module enc_sequencer
    import enc_pkg::*;
#(
    parameter int ENC_SYM     = ENC_SYM_DEF,
    parameter int RSC_PAR_LEN = RSC_PAR_LEN_DEF,
    parameter int RSC_COD_MAX = RSC_COD_MAX_DEF,
    parameter int RSC_MES_MIN = RSC_MES_MIN_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gen_valid,
    input  logic [$clog2(RSC_COD_MAX+1)-1:0]   cfg_mes_len,
    output logic [$clog2(RSC_COD_MAX)-1:0]     con_counter,
    output sel_phase_t                         sel_phase,
    output logic [$clog2(ENC_SYM+1)-1:0]       mes_request,
    output logic [$clog2(ENC_SYM+1)-1:0]       par_request,
    output logic                               sop,
    output logic [$clog2(ENC_SYM)-1:0]         sop_lane,
    output logic                               eop,
    output logic [$clog2(ENC_SYM)-1:0]         eop_lane,
    output logic                               pro_finished,
    output logic [$clog2(RSC_COD_MAX+1)-1:0]   cur_mes_len,
    output logic                               cfg_err,
    output logic [CW_COUNT_W-1:0]              cw_count
);
    localparam int KW  = $clog2(RSC_COD_MAX + 1);
    localparam int CNW = $clog2(RSC_COD_MAX);
    localparam int SW  = $clog2(RSC_COD_MAX + ENC_SYM + 1);
    localparam int RW  = $clog2(ENC_SYM + 1);
    localparam int LW  = $clog2(ENC_SYM);

    logic [SW-1:0]         cnt_cur;
    logic [SW-1:0]         k_cur;
    logic [SW-1:0]         n_cur;
    logic [SW-1:0]         beat_end;
    logic [SW-1:0]         cnt_nxt;
    logic [SW-1:0]         k_nxt;
    logic [SW-1:0]         n_nxt;
    logic                  wrap;
    logic                  cfg_legal;
    logic                  err_nxt;
    logic                  fin_nxt;
    logic [CW_COUNT_W-1:0] cw_nxt;

    sel_phase_t            nx_phase;
    logic [RW-1:0]         nx_mes;
    logic [RW-1:0]         nx_par;
    logic                  nx_sop;
    logic [LW-1:0]         nx_sop_lane;
    logic                  nx_eop;
    logic [LW-1:0]         nx_eop_lane;

    always_comb begin
        cnt_cur   = SW'(con_counter);
        k_cur     = SW'(cur_mes_len);
        n_cur     = k_cur + SW'(RSC_PAR_LEN);
        beat_end  = cnt_cur + SW'(ENC_SYM);
        wrap      = (beat_end >= n_cur);
        cfg_legal = enc_mes_len_legal(int'(cfg_mes_len), RSC_MES_MIN, RSC_COD_MAX, RSC_PAR_LEN);

        cnt_nxt = cnt_cur;
        k_nxt   = k_cur;
        cw_nxt  = cw_count;
        err_nxt = cfg_err;
        fin_nxt = 1'b0;

        if (rst) begin
            cnt_nxt = '0;
            k_nxt   = cfg_legal ? SW'(cfg_mes_len) : SW'(RSC_COD_MAX - RSC_PAR_LEN);
            cw_nxt  = '0;
            err_nxt = 1'b0;
        end else if (gen_valid) begin
            // The beat being consumed holds message position K-1.
            fin_nxt = (cnt_cur < k_cur) && (beat_end >= k_cur);
            if (wrap) begin
                cnt_nxt = beat_end - n_cur;
                cw_nxt  = cw_count + CW_COUNT_W'(1);
                if (cfg_legal) begin
                    k_nxt = SW'(cfg_mes_len);
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = beat_end;
            end
        end
        n_nxt = k_nxt + SW'(RSC_PAR_LEN);
    end

    // Outputs are registered from the classification of the next state, so
    // they always describe the beat presented in the following cycle.
    enc_beat_classifier #(
        .ENC_SYM (ENC_SYM),
        .SW      (SW)
    ) u_classifier (
        .cnt         (cnt_nxt),
        .mes_len     (k_nxt),
        .cod_len     (n_nxt),
        .phase       (nx_phase),
        .mes_request (nx_mes),
        .par_request (nx_par),
        .sop         (nx_sop),
        .sop_lane    (nx_sop_lane),
        .eop         (nx_eop),
        .eop_lane    (nx_eop_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            con_counter  <= '0;
            cur_mes_len  <= KW'(k_nxt);
            cw_count     <= '0;
            cfg_err      <= 1'b0;
            pro_finished <= 1'b0;
        end else begin
            con_counter  <= CNW'(cnt_nxt);
            cur_mes_len  <= KW'(k_nxt);
            cw_count     <= cw_nxt;
            cfg_err      <= err_nxt;
            pro_finished <= fin_nxt;
        end
        sel_phase   <= nx_phase;
        mes_request <= nx_mes;
        par_request <= nx_par;
        sop         <= nx_sop;
        sop_lane    <= nx_sop_lane;
        eop         <= nx_eop;
        eop_lane    <= nx_eop_lane;
    end

endmodule
